// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage for the pipelined MIPS core. It owns the PC and a
//   word-organised instruction memory. A debug/UART loader fills the memory
//   byte-serially. The stage delivers a registered instruction, PC and PC+4 to
//   IF/ID, and handles stall, branch redirect, HALT detection and restart.
//
//   Optional build macro: IF_STEP_EN adds the i_step input. With it, RUN
//   advances only in cycles with i_step = 1 (debug single-step).
//
// Ports:
//   i_clk, i_reset         clock (rising edge); asynchronous active-low reset
//   i_load_en, i_load_byte program byte stream, big-endian (first byte = MSB)
//   i_start                begin or restart execution at PC 0
//   i_stall                hold PC and outputs
//   i_branch_taken/target  redirect the PC to a byte address
//   i_step                 (IF_STEP_EN only) permit one fetch/advance
//   o_instr, o_pc,         fetched instruction (0 = bubble), its address,
//   o_pc_plus4, o_valid    address + 4, and a real-instruction flag
//   o_halted               HALT word fetched; core stopped
//   o_words_loaded         complete words written since the load began
//   o_state                00 IDLE, 01 LOAD, 10 RUN, 11 HALTED
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int unsigned           SIZE_PC   = 32,
    parameter int unsigned           SIZE_INST = 32,
    parameter int unsigned           MEM_DEPTH = 256,
    parameter logic [SIZE_INST-1:0]  HALT_WORD = {SIZE_INST{1'b1}}
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_load_en,
    input  logic [7:0]                    i_load_byte,
    input  logic                          i_start,
    input  logic                          i_stall,
    input  logic                          i_branch_taken,
    input  logic [SIZE_PC-1:0]            i_branch_target,
`ifdef IF_STEP_EN
    input  logic                          i_step,
`endif
    output logic [SIZE_INST-1:0]          o_instr,
    output logic [SIZE_PC-1:0]            o_pc,
    output logic [SIZE_PC-1:0]            o_pc_plus4,
    output logic                          o_valid,
    output logic                          o_halted,
    output logic [$clog2(MEM_DEPTH):0]    o_words_loaded,
    output logic [1:0]                    o_state
);

    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
    localparam int unsigned WCNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOAD   = 2'b01,
        S_RUN    = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [SIZE_PC-1:0]   pc_q, pc_d;
    logic [SIZE_INST-1:0] instr_q, instr_d;
    logic [SIZE_PC-1:0]   opc_q, opc_d;
    logic [SIZE_PC-1:0]   opc4_q, opc4_d;
    logic                 valid_q, valid_d;
    logic                 halted_q, halted_d;
    logic [WCNT_W-1:0]    words_q, words_d;
    logic [ADDR_W-1:0]    wptr_q, wptr_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic [23:0]          asm_q, asm_d;     // first three bytes of the word in flight

    logic [SIZE_INST-1:0] mem [MEM_DEPTH];
    logic                 mem_we_c;
    logic [ADDR_W-1:0]    mem_waddr_c;
    logic [SIZE_INST-1:0] mem_wdata_c;
    logic [SIZE_INST-1:0] rd_word_c;
    logic                 advance_c;

    // Word index ignores the byte offset and any address bits above the memory.
    assign rd_word_c = mem[pc_q[ADDR_W+1:2]];

`ifdef IF_STEP_EN
    assign advance_c = i_step && !i_stall;
`else
    assign advance_c = !i_stall;
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            opc_q    <= '0;
            opc4_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            words_q  <= '0;
            wptr_q   <= '0;
            bcnt_q   <= '0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            opc_q    <= opc_d;
            opc4_q   <= opc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            words_q  <= words_d;
            wptr_q   <= wptr_d;
            bcnt_q   <= bcnt_d;
            asm_q    <= asm_d;
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        opc_d       = opc_q;
        opc4_d      = opc4_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        words_d     = words_q;
        wptr_d      = wptr_q;
        bcnt_d      = bcnt_q;
        asm_d       = asm_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = wptr_q;
        mem_wdata_c = SIZE_INST'({asm_q, i_load_byte});

        unique case (state_q)
            S_IDLE: begin
                if (i_load_en) begin
                    state_d = S_LOAD;
                    wptr_d  = '0;
                    words_d = '0;
                    asm_d   = 24'(i_load_byte);
                    bcnt_d  = 2'd1;
                end else if (i_start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end

            S_LOAD: begin
                if (i_start) begin
                    // Any partially assembled word is dropped.
                    state_d = S_RUN;
                    pc_d    = '0;
                    bcnt_d  = '0;
                end else if (i_load_en) begin
                    asm_d = {asm_q[15:0], i_load_byte};
                    if (bcnt_q == 2'd3) begin
                        mem_we_c = 1'b1;
                        wptr_d   = wptr_q + ADDR_W'(1);
                        bcnt_d   = '0;
                        if (words_q != WCNT_W'(MEM_DEPTH)) begin
                            words_d = words_q + WCNT_W'(1);
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end

            S_RUN: begin
                if (i_branch_taken) begin
                    // Redirect wins over stall and over a HALT fetched now.
                    pc_d    = i_branch_target;
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (advance_c) begin
                    instr_d = rd_word_c;
                    opc_d   = pc_q;
                    opc4_d  = pc_q + SIZE_PC'(4);
                    valid_d = 1'b1;
                    if (rd_word_c == HALT_WORD) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + SIZE_PC'(4);
                    end
                end
            end

            S_HALTED: begin
                instr_d = '0;
                valid_d = 1'b0;
                if (i_load_en) begin
                    state_d  = S_LOAD;
                    halted_d = 1'b0;
                    wptr_d   = '0;
                    words_d  = '0;
                    asm_d    = 24'(i_load_byte);
                    bcnt_d   = 2'd1;
                end else if (i_start) begin
                    state_d  = S_RUN;
                    halted_d = 1'b0;
                    pc_d     = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign o_instr        = instr_q;
    assign o_pc           = opc_q;
    assign o_pc_plus4     = opc4_q;
    assign o_valid        = valid_q;
    assign o_halted       = halted_q;
    assign o_words_loaded = words_q;
    assign o_state        = state_q;

endmodule
